dot_accumulator: RTL and testbench
==================================

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 14, width of the signed partial dot product from the upstream vector-product stage.
REQ-002 SHALL have parameter ACC_WIDTH, default 20, width of the signed running accumulator.
REQ-003 SHALL have parameter OUT_WIDTH, default 4, width of the signed requantized result.
REQ-004 SHALL have parameter SHIFT_WIDTH, default 4, width of the runtime requantization shift.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port i_valid, input, 1, upstream beat valid.
REQ-008 SHALL have port o_ready, output, 1, block can accept a beat.
REQ-009 SHALL have port i_product, input, PROD_WIDTH, signed partial product.
REQ-010 SHALL have port i_last, input, 1, marks the final beat of one dot product.
REQ-011 SHALL have port i_shift, input, SHIFT_WIDTH, unsigned right-shift amount, sampled on the last beat.
REQ-012 SHALL have port o_valid, output, 1, result valid.
REQ-013 SHALL have port i_ready, input, 1, downstream accepts result.
REQ-014 SHALL have port o_result, output, OUT_WIDTH, signed requantized result.
REQ-015 SHALL have port o_overflow, output, 1, result was clamped by saturation.

Function
REQ-016 SHALL implement a two-state FSM: ACCUM (o_ready=1, o_valid=0) and HOLD (o_ready=0, o_valid=1).
REQ-017 SHALL accept a beat only when i_valid && o_ready; beats with i_valid low, or presented in HOLD, SHALL be ignored.
REQ-018 SHALL sign-extend i_product to ACC_WIDTH; the first beat after reset or after a result is accepted loads acc = product, later beats add acc = acc + product.
REQ-019 SHALL wrap the accumulator modulo 2^ACC_WIDTH (two's complement), with no internal saturation.
REQ-020 On an accepted beat with i_last=1, SHALL requantize total = acc + product (or product alone if it is also the first beat), register o_result/o_overflow, and enter HOLD; result is visible the cycle after the last beat.
REQ-021 Requantization: shift==0 gives r=total; otherwise r=(total + 2^(shift-1)) >>> shift, computed in ACC_WIDTH+1 bits (round half up).
REQ-022 SHALL clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and set o_overflow=1 iff clamping occurred.
REQ-023 In HOLD, o_result and o_overflow SHALL remain stable until i_ready=1; that edge returns to ACCUM, drops o_valid, and marks the next beat as first.
REQ-024 SHALL NOT bypass: minimum one bubble cycle between a last beat and the next accepted beat.

Reset
REQ-025 While i_rst_n=0: state=ACCUM, acc=0, first-flag=1, o_valid=0, o_result=0, o_overflow=0, o_ready=1 after release.
REQ-026 Reset asserted mid-accumulation or in HOLD SHALL discard the partial sum and any pending result.

Configuration
REQ-027 With macro DOT_ACC_RELU_EN defined, negative r SHALL become 0 before saturation (o_overflow unaffected by ReLU); without it, signed results pass unchanged.

Structure
REQ-028 PROD_WIDTH, ACC_WIDTH, OUT_WIDTH, SHIFT_WIDTH defaults and the FSM state encoding SHALL live in a shared package.
REQ-029 Round/shift/ReLU/saturate logic SHALL be one combinational sub-module, requant_sat; FSM and accumulator stay in dot_accumulator.

Verification
REQ-030 Single beat product=13, last, shift=1 -> o_result=7, o_overflow=0, o_valid one cycle later.
REQ-031 Beats 100,-20,50,6 (last on 6), shift=4 -> total 136, r=9 -> o_result=7, o_overflow=1.
REQ-032 Beats -3,-4 (last), shift=0 -> o_result=-7 (4'b1001), o_overflow=0; with DOT_ACC_RELU_EN -> o_result=0.
REQ-033 Hold i_ready=0 for 5 cycles with i_valid=1 -> o_result stable, o_ready=0, no beats absorbed; i_ready=1 -> next beat treated as first.
REQ-034 Beats 50,50, then reset pulse, then single beat 3, last, shift=0 -> o_result=3.
REQ-035 Beats -7 (last), shift=1 -> (-7+1)>>>1 = -3, o_result=-3, o_overflow=0.

Source files
------------

// File: rtl/dot_accumulator_pkg.sv
// Shared widths and FSM encoding for the dot-product accumulator slice.
package dot_accumulator_pkg;

    localparam int unsigned PROD_WIDTH_DEF  = 14;
    localparam int unsigned ACC_WIDTH_DEF   = 20;
    localparam int unsigned OUT_WIDTH_DEF   = 4;
    localparam int unsigned SHIFT_WIDTH_DEF = 4;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/requant_sat.sv
// Round-half-up right shift, optional ReLU and output saturation.
// Optional feature: define DOT_ACC_RELU_EN to zero negative results before saturation.
module requant_sat
    import dot_accumulator_pkg::*;
#(
    parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int unsigned SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
    input  logic signed [ACC_WIDTH-1:0]   total,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [OUT_WIDTH-1:0]   result_c,
    output logic                          overflow_c
);

    // One guard bit so the rounding increment cannot wrap the sum.
    localparam int unsigned EXT_WIDTH = ACC_WIDTH + 1;
    localparam logic signed [EXT_WIDTH-1:0] OUT_MAX =
        EXT_WIDTH'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
    localparam logic signed [EXT_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [EXT_WIDTH-1:0] total_ext;
    logic signed [EXT_WIDTH-1:0] half;
    logic signed [EXT_WIDTH-1:0] shifted;

    // Requantize: round, shift, rectify, clamp.
    always_comb begin
        total_ext  = {total[ACC_WIDTH-1], total};
        half       = '0;
        shifted    = total_ext;
        result_c   = '0;
        overflow_c = 1'b0;

        if (shift != '0) begin
            half    = EXT_WIDTH'(1) << (shift - SHIFT_WIDTH'(1));
            shifted = (total_ext + half) >>> shift;
        end

`ifdef DOT_ACC_RELU_EN
        if (shifted < 0) begin
            shifted = '0;
        end
`endif

        if (shifted > OUT_MAX) begin
            result_c   = OUT_WIDTH'(OUT_MAX);
            overflow_c = 1'b1;
        end else if (shifted < OUT_MIN) begin
            result_c   = OUT_WIDTH'(OUT_MIN);
            overflow_c = 1'b1;
        end else begin
            result_c   = OUT_WIDTH'(shifted);
        end
    end

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates signed partial products over a burst and holds the
// requantized result until downstream accepts it.
// Optional feature: DOT_ACC_RELU_EN (applied inside requant_sat).
module dot_accumulator
    import dot_accumulator_pkg::*;
#(
    parameter int unsigned PROD_WIDTH  = PROD_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int unsigned SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [PROD_WIDTH-1:0]  i_product,
    input  logic                   i_last,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [OUT_WIDTH-1:0]   o_result,
    output logic                   o_overflow
);

    state_e                      state_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        first_q;

    logic signed [PROD_WIDTH-1:0] prod_s;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  total_c;
    logic                         accept_c;
    logic signed [OUT_WIDTH-1:0]  req_result_c;
    logic                         req_overflow_c;

    // Running sum including the beat currently presented; wraps at ACC_WIDTH.
    always_comb begin
        prod_s   = i_product;
        prod_ext = ACC_WIDTH'(prod_s);
        total_c  = first_q ? prod_ext : (acc_q + prod_ext);
        accept_c = i_valid && o_ready;
    end

    requant_sat #(
        .ACC_WIDTH   (ACC_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant_sat (
        .total      (total_c),
        .shift      (i_shift),
        .result_c   (req_result_c),
        .overflow_c (req_overflow_c)
    );

    // Accumulate beats, capture on the last one, hold until accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            first_q    <= 1'b1;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_overflow <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept_c) begin
                        acc_q   <= total_c;
                        first_q <= 1'b0;
                        if (i_last) begin
                            o_result   <= req_result_c;
                            o_overflow <= req_overflow_c;
                            o_valid    <= 1'b1;
                            o_ready    <= 1'b0;
                            state_q    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        first_q <= 1'b1;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state_q <= ST_ACCUM;
                    end
                end
                default: begin
                    first_q <= 1'b1;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// Scoreboard bench for dot_accumulator: the driver queues expected results,
// a negedge monitor compares each presented result and its stability.
module tb_dot_accumulator;

    localparam int unsigned PW = 14;
    localparam int unsigned AW = 20;
    localparam int unsigned OW = 4;
    localparam int unsigned SW = 4;

`ifdef DOT_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [PW-1:0] i_product;
    logic          i_last;
    logic [SW-1:0] i_shift;
    logic          o_valid;
    logic          i_ready;
    logic [OW-1:0] o_result;
    logic          o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OW:0] exp_q[$];
    logic [OW:0] held;
    logic [OW:0] exp_e;
    bit          seen = 1'b0;

    dot_accumulator #(
        .PROD_WIDTH  (PW),
        .ACC_WIDTH   (AW),
        .OUT_WIDTH   (OW),
        .SHIFT_WIDTH (SW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_product  (i_product),
        .i_last     (i_last),
        .i_shift    (i_shift),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on each newly presented result, then demand stability.
    always @(negedge i_clk) begin
        if (!o_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            held = {o_overflow, o_result};
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("result", int'($signed(o_result)), int'($signed(exp_e[OW-1:0])));
                check("overflow", int'(o_overflow), int'(exp_e[OW]));
            end
        end else begin
            check("hold_stable", int'({o_overflow, o_result}), int'(held));
        end
        check("ready_vs_valid", int'(o_ready), int'(!o_valid));
    end

    task automatic idle_inputs();
        i_valid   = 1'b0;
        i_last    = 1'b0;
        i_product = PW'(99);
        i_shift   = SW'(7);
    endtask

    task automatic beat(input int p);
        i_valid   = 1'b1;
        i_product = PW'(p);
        i_last    = 1'b0;
        i_shift   = SW'(7);
        @(posedge i_clk); #1;
        idle_inputs();
    endtask

    // Last beat: queue the expectation and confirm one-cycle latency.
    task automatic last_beat(input int p, input int sh, input int exp_r, input bit exp_o);
        i_valid   = 1'b1;
        i_product = PW'(p);
        i_last    = 1'b1;
        i_shift   = SW'(sh);
        exp_q.push_back({exp_o, OW'(exp_r)});
        @(posedge i_clk); #1;
        idle_inputs();
        @(negedge i_clk);
        check("latency_valid", int'(o_valid), 1);
    endtask

    task automatic ack();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("rst_valid", int'(o_valid), 0);
        check("rst_result", int'(o_result), 0);
        check("rst_overflow", int'(o_overflow), 0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_ready = 1'b0;
        idle_inputs();
        repeat (3) @(negedge i_clk);
        check("rst_valid", int'(o_valid), 0);
        check("rst_ready", int'(o_ready), 1);
        check("rst_result", int'(o_result), 0);
        check("rst_overflow", int'(o_overflow), 0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Single beat, round half up: (13+1)>>>1 = 7.
        last_beat(13, 1, 7, 1'b0);
        ack();

        // Multi-beat with an idle gap: total 136, r=9 -> clamp 7.
        beat(100);
        beat(-20);
        @(posedge i_clk); #1;
        beat(50);
        last_beat(6, 4, 7, 1'b1);
        ack();

        // Negative total, no shift.
        beat(-3);
        last_beat(-4, 0, RELU ? 0 : -7, 1'b0);
        ack();

        // Negative rounding: (-7+1)>>>1 = -3.
        last_beat(-7, 1, RELU ? 0 : -3, 1'b0);
        ack();

        // Negative saturation: (-2000+8)>>>4 = -125 -> -8.
        last_beat(-2000, 4, RELU ? 0 : -8, RELU ? 1'b0 : 1'b1);
        ack();

        // Clamp boundaries at shift 0.
        last_beat(7, 0, 7, 1'b0);
        ack();
        last_beat(8, 0, 7, 1'b1);
        ack();
        last_beat(-8, 0, RELU ? 0 : -8, 1'b0);
        ack();
        last_beat(-9, 0, RELU ? 0 : -8, RELU ? 1'b0 : 1'b1);
        ack();

        // 1+2=3, (3+1)>>>1 = 2.
        beat(1);
        last_beat(2, 1, 2, 1'b0);
        ack();

        // Back-pressure: beats offered in HOLD must be ignored.
        last_beat(5, 0, 5, 1'b0);
        i_valid   = 1'b1;
        i_product = PW'(1);
        i_last    = 1'b1;
        i_shift   = SW'(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            check("hold_not_ready", int'(o_ready), 0);
        end
        @(posedge i_clk); #1;
        idle_inputs();
        ack();
        last_beat(2, 0, 2, 1'b0);
        ack();

        // Accumulator wrap: 65*8191 = 532415 -> -516161; >>>15 -> -16 -> -8.
        for (int k = 0; k < 64; k++) beat(8191);
        last_beat(8191, 15, RELU ? 0 : -8, RELU ? 1'b0 : 1'b1);
        ack();

        // Reset mid-accumulation discards the partial sum.
        beat(50);
        beat(50);
        reset_pulse();
        last_beat(3, 0, 3, 1'b0);
        ack();

        // Reset in HOLD discards the pending result.
        last_beat(6, 0, 6, 1'b0);
        reset_pulse();
        check("post_rst_ready", int'(o_ready), 1);
        last_beat(-1, 1, 0, 1'b0);
        ack();

        repeat (3) @(posedge i_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
